hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 35 +++
 rtl/hazard_ctrl_if.sv | 40 ++++
 rtl/hazard_ctrl_match.sv | 27 ++
 rtl/hazard_ctrl.sv | 108 ++++++++++
 tb/tb_hazard_ctrl.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings and tracker-slot type for the pipeline hazard controller.
// Forwarding is enabled by defining HAZARD_FORWARD_EN.
package hazard_ctrl_pkg;

    // Tracker slots hold destination addresses zero-extended to this width; REG_AW must not exceed it.
    localparam int unsigned MAX_AW = 8;

    localparam logic [1:0] HIT_EX  = 2'd0;
    localparam logic [1:0] HIT_MEM = 2'd1;
    localparam logic [1:0] HIT_WB  = 2'd2;

    typedef enum logic [1:0] {
        FWD_RF    = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2,
        FWD_RSVD  = 2'd3
    } fwd_sel_e;

    typedef struct packed {
        logic              valid;
        logic [MAX_AW-1:0] rd;
        logic              wen;
        logic              load;
    } trk_slot_t;

    localparam trk_slot_t SLOT_EMPTY = '0;

    // Youngest producer wins; a load still in EX cannot forward and is handled by the stall path.
    function automatic fwd_sel_e pick_fwd(input logic [2:0] hit, input logic ex_load);
        if (hit[HIT_EX] && !ex_load) return FWD_EXMEM;
        if (hit[HIT_MEM])            return FWD_MEMWB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode/execute hazard-control bundle between the pipeline and hazard_ctrl.
// Width parameters must match those of the hazard_ctrl instance it connects to.
interface hazard_ctrl_if #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 32
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1_addr;
    logic              id_rs1_used;
    logic [REG_AW-1:0] id_rs2_addr;
    logic              id_rs2_used;
    logic [REG_AW-1:0] id_rd_addr;
    logic              id_rd_wen;
    logic              id_is_load;
    logic              ex_branch_taken;
    logic              mem_busy;

    logic              stall_if;
    logic              stall_id;
    logic              bubble_ex;
    logic              flush_id;
    logic [1:0]        fwd_a_sel;
    logic [1:0]        fwd_b_sel;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output id_valid, id_rs1_addr, id_rs1_used, id_rs2_addr, id_rs2_used,
               id_rd_addr, id_rd_wen, id_is_load, ex_branch_taken, mem_busy,
        input  stall_if, stall_id, bubble_ex, flush_id, fwd_a_sel, fwd_b_sel,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs1_addr, id_rs1_used, id_rs2_addr, id_rs2_used,
               id_rd_addr, id_rd_wen, id_is_load, ex_branch_taken, mem_busy,
        output stall_if, stall_id, bubble_ex, flush_id, fwd_a_sel, fwd_b_sel,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl_match.sv
// hazard_match: compares one decode source against the EX/MEM/WB tracker slots.
// Register x0 never produces a hit.
module hazard_match
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic [REG_AW-1:0] src_addr,
    input  logic              src_used,
    input  trk_slot_t         ex_slot,
    input  trk_slot_t         mem_slot,
    input  trk_slot_t         wb_slot,
    output logic [2:0]        hit
);
    logic [MAX_AW-1:0] src_ext;

    assign src_ext = MAX_AW'(src_addr);

    always_comb begin
        hit = '0;
        if (src_used && (src_ext != '0)) begin
            hit[HIT_EX]  = ex_slot.valid  && ex_slot.wen  && (ex_slot.rd  == src_ext);
            hit[HIT_MEM] = mem_slot.valid && mem_slot.wen && (mem_slot.rd == src_ext);
            hit[HIT_WB]  = wb_slot.valid  && wb_slot.wen  && (wb_slot.rd  == src_ext);
        end
    end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use / RAW stall, branch flush, operand forwarding and perf counters.
// Define HAZARD_FORWARD_EN to forward from EX/MEM and MEM/WB; otherwise RAW hazards stall.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 32
) (
    input  logic          clk,
    input  logic          reset,
    hazard_ctrl_if.slave  bus
);
    trk_slot_t        ex_q, mem_q, wb_q, id_slot;
    logic [2:0]       hit_a, hit_b;
    logic             hz_stall;
    logic             stall, bubble, flush, cnt_stall_inc;
    fwd_sel_e         fwd_a, fwd_b;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic             slot_unused;

    hazard_match #(.REG_AW(REG_AW)) u_match_a (
        .src_addr (bus.id_rs1_addr),
        .src_used (bus.id_valid & bus.id_rs1_used),
        .ex_slot  (ex_q),
        .mem_slot (mem_q),
        .wb_slot  (wb_q),
        .hit      (hit_a)
    );

    hazard_match #(.REG_AW(REG_AW)) u_match_b (
        .src_addr (bus.id_rs2_addr),
        .src_used (bus.id_valid & bus.id_rs2_used),
        .ex_slot  (ex_q),
        .mem_slot (mem_q),
        .wb_slot  (wb_q),
        .hit      (hit_b)
    );

    // WB hits resolve through the write-first regfile; nothing else reads them.
    assign slot_unused = ^{hit_a[HIT_WB], hit_b[HIT_WB], wb_q.load};

`ifdef HAZARD_FORWARD_EN
    assign hz_stall = ex_q.load & (hit_a[HIT_EX] | hit_b[HIT_EX]);
    assign fwd_a    = pick_fwd(hit_a, ex_q.load);
    assign fwd_b    = pick_fwd(hit_b, ex_q.load);
`else
    assign hz_stall = hit_a[HIT_EX] | hit_a[HIT_MEM] | hit_b[HIT_EX] | hit_b[HIT_MEM];
    assign fwd_a    = FWD_RF;
    assign fwd_b    = FWD_RF;
`endif

    // Priority: memory freeze, then branch flush, then hazard stall.
    always_comb begin
        stall         = 1'b0;
        bubble        = 1'b0;
        flush         = 1'b0;
        cnt_stall_inc = 1'b0;
        if (bus.mem_busy) begin
            stall = 1'b1;
        end else if (bus.ex_branch_taken) begin
            flush  = 1'b1;
            bubble = 1'b1;
        end else if (hz_stall) begin
            stall         = 1'b1;
            bubble        = 1'b1;
            cnt_stall_inc = 1'b1;
        end
    end

    always_comb begin
        id_slot       = SLOT_EMPTY;
        id_slot.valid = bus.id_valid & ~stall & ~flush;
        id_slot.rd    = MAX_AW'(bus.id_rd_addr);
        id_slot.wen   = bus.id_rd_wen;
        id_slot.load  = bus.id_is_load;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q  <= SLOT_EMPTY;
            mem_q <= SLOT_EMPTY;
            wb_q  <= SLOT_EMPTY;
        end else if (!bus.mem_busy) begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            ex_q  <= id_slot;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (cnt_stall_inc && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (flush && (flush_cnt_q != '1))         flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign bus.stall_if  = stall;
    assign bus.stall_id  = stall;
    assign bus.bubble_ex = bubble;
    assign bus.flush_id  = flush;
    assign bus.fwd_a_sel = fwd_a;
    assign bus.fwd_b_sel = fwd_b;
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vector table, corner sequences and
// randomized traffic against an in-flight-instruction reference model.
module tb_hazard_ctrl;
    localparam int TB_AW    = 5;
    localparam int TB_CNT_W = 4;
    localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

    logic clk;
    logic reset;

    hazard_ctrl_if #(.REG_AW(TB_AW), .CNT_W(TB_CNT_W)) bus ();

    hazard_ctrl #(.REG_AW(TB_AW), .CNT_W(TB_CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: producers in flight, indexed by age (1 = one instruction ahead).
    typedef struct { bit valid; int rd; bit wen; bit load; } prod_t;
    prod_t pipe [1:3];
    int    m_scnt, m_fcnt;
    bit    e_stall, e_bubble, e_flush, e_cnt_stall;
    int    e_fa, e_fb;
    logic  obs_stall, obs_bubble, obs_flush;
    logic [1:0] obs_fa, obs_fb;

    typedef struct {
        int prd; bit pload;
        int rs1; bit u1; int rs2; bit u2;
        int st_fwd; int fa_fwd; int fb_fwd; int st_nf;
    } vec_t;
    vec_t vecs [6];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic bit src_match(int age, int rs, bit used);
        return bus.id_valid && used && rs != 0 && pipe[age].valid && pipe[age].wen
               && pipe[age].rd == rs;
    endfunction

    function automatic int sel_for(int rs, bit used);
`ifdef HAZARD_FORWARD_EN
        if (src_match(1, rs, used) && !pipe[1].load) return 1;
        if (src_match(2, rs, used)) return 2;
`endif
        return 0;
    endfunction

    function automatic void model_check();
        int rs1, rs2;
        bit u1, u2, hz;
        rs1 = int'(bus.id_rs1_addr); u1 = bus.id_rs1_used;
        rs2 = int'(bus.id_rs2_addr); u2 = bus.id_rs2_used;
`ifdef HAZARD_FORWARD_EN
        hz = pipe[1].load && (src_match(1, rs1, u1) || src_match(1, rs2, u2));
`else
        hz = src_match(1, rs1, u1) || src_match(2, rs1, u1)
          || src_match(1, rs2, u2) || src_match(2, rs2, u2);
`endif
        e_stall = 0; e_bubble = 0; e_flush = 0; e_cnt_stall = 0;
        if (bus.mem_busy) e_stall = 1;
        else if (bus.ex_branch_taken) begin e_flush = 1; e_bubble = 1; end
        else if (hz) begin e_stall = 1; e_bubble = 1; e_cnt_stall = 1; end
        e_fa = sel_for(rs1, u1);
        e_fb = sel_for(rs2, u2);
        chk("stall_if",  bus.stall_if,  e_stall);
        chk("stall_id",  bus.stall_id,  e_stall);
        chk("bubble_ex", bus.bubble_ex, e_bubble);
        chk("flush_id",  bus.flush_id,  e_flush);
        chk("fwd_a_sel", bus.fwd_a_sel, e_fa);
        chk("fwd_b_sel", bus.fwd_b_sel, e_fb);
        chk("stall_cnt", bus.stall_cnt, m_scnt);
        chk("flush_cnt", bus.flush_cnt, m_fcnt);
    endfunction

    function automatic void model_update();
        if (reset) begin
            for (int i = 1; i <= 3; i++) pipe[i] = '{0, 0, 0, 0};
            m_scnt = 0;
            m_fcnt = 0;
        end else begin
            if (e_cnt_stall && m_scnt < CNT_MAX) m_scnt++;
            if (e_flush && m_fcnt < CNT_MAX) m_fcnt++;
            if (!bus.mem_busy) begin
                pipe[3] = pipe[2];
                pipe[2] = pipe[1];
                pipe[1] = '{bus.id_valid && !e_stall && !e_flush, int'(bus.id_rd_addr),
                            bus.id_rd_wen, bus.id_is_load};
            end
        end
    endfunction

    task automatic tick();
        @(negedge clk);
        model_check();
        obs_stall  = bus.stall_id;
        obs_bubble = bus.bubble_ex;
        obs_flush  = bus.flush_id;
        obs_fa     = bus.fwd_a_sel;
        obs_fb     = bus.fwd_b_sel;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drive_id(bit v, int rs1, bit u1, int rs2, bit u2, int rd, bit wen, bit ld);
        bus.id_valid    = v;
        bus.id_rs1_addr = TB_AW'(rs1);
        bus.id_rs1_used = u1;
        bus.id_rs2_addr = TB_AW'(rs2);
        bus.id_rs2_used = u2;
        bus.id_rd_addr  = TB_AW'(rd);
        bus.id_rd_wen   = wen;
        bus.id_is_load  = ld;
    endtask

    task automatic idle();
        drive_id(0, 0, 0, 0, 0, 0, 0, 0);
        bus.ex_branch_taken = 0;
        bus.mem_busy        = 0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        tick();
        reset = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1;
        idle();
        for (int i = 1; i <= 3; i++) pipe[i] = '{0, 0, 0, 0};
        m_scnt = 0;
        m_fcnt = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 0;

        // Reset state with idle inputs.
        tick();
        chk("rst_stall", obs_stall, 0);
        chk("rst_flush", obs_flush, 0);
        chk("rst_fwd_a", obs_fa, 0);

        //           prd pl rs1 u1 rs2 u2 st_f fa_f fb_f st_nf
        vecs[0] = '{5, 1, 5, 1, 1, 1, 1, 2, 0, 2};   // lw x5; add x6,x5,x1
        vecs[1] = '{5, 0, 1, 1, 5, 1, 0, 0, 1, 2};   // add x5; sub x7,x1,x5
        vecs[2] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0};   // x0 never hazards
        vecs[3] = '{5, 0, 5, 0, 2, 1, 0, 0, 0, 0};   // matching source not used
        vecs[4] = '{7, 1, 7, 1, 7, 1, 1, 2, 2, 2};   // both sources hit a load
        vecs[5] = '{9, 0, 3, 1, 4, 1, 0, 0, 0, 0};   // no match
        foreach (vecs[v]) begin
            int exp_st, exp_fa, exp_fb;
`ifdef HAZARD_FORWARD_EN
            exp_st = vecs[v].st_fwd; exp_fa = vecs[v].fa_fwd; exp_fb = vecs[v].fb_fwd;
`else
            exp_st = vecs[v].st_nf;  exp_fa = 0;              exp_fb = 0;
`endif
            do_reset();
            drive_id(1, 0, 0, 0, 0, vecs[v].prd, 1, vecs[v].pload);
            tick();
            drive_id(1, vecs[v].rs1, vecs[v].u1, vecs[v].rs2, vecs[v].u2, 10, 1, 0);
            n = 0;
            for (int k = 0; k < 6; k++) begin
                tick();
                if (!obs_stall) break;
                n++;
            end
            chk($sformatf("vec%0d_stalls", v), n, exp_st);
            chk($sformatf("vec%0d_fwd_a", v), obs_fa, exp_fa);
            chk($sformatf("vec%0d_fwd_b", v), obs_fb, exp_fb);
            chk($sformatf("vec%0d_stall_cnt", v), bus.stall_cnt, exp_st);
        end

        // Load-use and branch in the same cycle: flush wins, no stall counted.
        do_reset();
        drive_id(1, 0, 0, 0, 0, 5, 1, 1);
        tick();
        drive_id(1, 5, 1, 1, 1, 6, 1, 0);
        bus.ex_branch_taken = 1;
        tick();
        chk("lu_br_flush", obs_flush, 1);
        chk("lu_br_stall", obs_stall, 0);
        chk("lu_br_fcnt", bus.flush_cnt, 1);
        chk("lu_br_scnt", bus.stall_cnt, 0);

        // mem_busy for three cycles over a pending load-use.
        do_reset();
        drive_id(1, 0, 0, 0, 0, 5, 1, 1);
        tick();
        drive_id(1, 5, 1, 1, 1, 6, 1, 0);
        bus.mem_busy = 1;
        repeat (3) begin
            tick();
            chk("busy_stall", obs_stall, 1);
            chk("busy_bubble", obs_bubble, 0);
        end
        chk("busy_scnt", bus.stall_cnt, 0);
        bus.mem_busy = 0;
        tick();
        chk("rel_bubble", obs_bubble, 1);
        chk("rel_scnt", bus.stall_cnt, 1);
        tick();
`ifdef HAZARD_FORWARD_EN
        chk("rel_resolved", obs_stall, 0);
        chk("rel_fwd_a", obs_fa, 2);
`else
        chk("rel_still_stalled", obs_stall, 1);
`endif

        // Branch held across mem_busy: flush taken on release.
        do_reset();
        bus.ex_branch_taken = 1;
        bus.mem_busy = 1;
        repeat (2) begin
            tick();
            chk("brbusy_flush", obs_flush, 0);
        end
        bus.mem_busy = 0;
        tick();
        chk("brbusy_rel_flush", obs_flush, 1);
        chk("brbusy_fcnt", bus.flush_cnt, 1);

        // Reset while stalling leaves nothing behind.
        do_reset();
        drive_id(1, 0, 0, 0, 0, 5, 1, 1);
        tick();
        drive_id(1, 5, 1, 0, 0, 6, 1, 0);
        tick();
        chk("pre_rst_stall", obs_stall, 1);
        reset = 1;
        tick();
        reset = 0;
        idle();
        tick();
        chk("post_rst_stall", obs_stall, 0);
        chk("post_rst_bubble", obs_bubble, 0);
        chk("post_rst_scnt", bus.stall_cnt, 0);

        // Counter saturation.
        do_reset();
        bus.ex_branch_taken = 1;
        repeat (18) tick();
        chk("flush_sat", bus.flush_cnt, CNT_MAX);
        do_reset();
        drive_id(1, 5, 1, 0, 0, 5, 1, 1);
        repeat (40) tick();
        chk("stall_sat", bus.stall_cnt, CNT_MAX);

        // Randomized traffic on a small register set to provoke hazards.
        do_reset();
        repeat (1500) begin
            drive_id($urandom_range(0, 9) < 8, $urandom_range(0, 3), $urandom_range(0, 1),
                     $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
                     $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 3);
            bus.ex_branch_taken = $urandom_range(0, 99) < 8;
            bus.mem_busy        = $urandom_range(0, 99) < 12;
            reset               = $urandom_range(0, 99) < 1;
            tick();
        end
        reset = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
